keypad_entry: RTL and testbench

//  Front-end time-entry stage for the microwave controller. It sits directly upstream of the

---
 rtl/keypad_entry.sv | 182 ++++++++++++++++++
 tb/tb_keypad_entry.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// Keypad time-entry front end: synchronises and debounces a one-hot 10-key pad and
// shifts each accepted digit into a 4-digit BCD MM:SS entry register.
module keypad_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [9:0] keypad,
  input  logic       entry_en,
  input  logic       entry_clr,
  output logic [3:0] mins_tens,
  output logic [3:0] mins_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       key_strobe,
  output logic       time_nonzero
);

  localparam int unsigned KEYS    = 10;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned ENTRY_W = DIGITS * DIG_W;
  localparam int unsigned KEEP_W  = ENTRY_W - DIG_W;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  // With a one-sample debounce the first matching sample is already the accepting one.
  localparam bit               FAST     = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_HELD,
    S_RELEASE
  } state_e;

  state_e              state_q;
  logic [KEYS-1:0]     kp_q;
  logic [KEYS-1:0]     key_ref_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ENTRY_W-1:0]  digits_q;
  logic [ENTRY_W-1:0]  digits_d;
  logic                strobe_q;

  logic                valid_key;
  logic                kp_zero;
  logic                ref_match;
  logic                accept;
  logic [CNT_W-1:0]    cnt_inc;
  logic [KEYS-1:0]     acc_key;
  logic [DIG_W-1:0]    key_idx;

  function automatic logic [DIG_W-1:0] bcd_of(input logic [KEYS-1:0] k);
    logic [DIG_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < KEYS; i++) begin
      if (k[i]) idx = DIG_W'(i);
    end
    return idx;
  endfunction

  // Accept decision and next value of the entry register
  always_comb begin
    valid_key = (kp_q != '0) && ((kp_q & (kp_q - KEYS'(1))) == '0);
    kp_zero   = (kp_q == '0);
    ref_match = (kp_q == key_ref_q);
    cnt_inc   = cnt_q + CNT_ONE;
    accept    = 1'b0;
    acc_key   = key_ref_q;
    digits_d  = digits_q;

    if (entry_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (FAST && valid_key) begin
            accept  = 1'b1;
            acc_key = kp_q;
          end
        end
        S_PRESS: begin
          if (ref_match && (cnt_inc == CNT_DONE)) accept = 1'b1;
        end
        default: accept = 1'b0;
      endcase
    end

    key_idx = bcd_of(acc_key);

    if (entry_en) begin
      if (entry_clr && accept) begin
        digits_d = {{KEEP_W{1'b0}}, key_idx};
      end else if (entry_clr) begin
        digits_d = '0;
      end else if (accept) begin
        digits_d = {digits_q[KEEP_W-1:0], key_idx};
      end
    end
  end

  // Input register, debounce FSM and entry register
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      key_ref_q <= '0;
      kp_q      <= '0;
      digits_q  <= '0;
      strobe_q  <= 1'b0;
    end else begin
      kp_q     <= keypad;
      digits_q <= digits_d;
      strobe_q <= accept;

      if (!entry_en) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (valid_key) begin
              key_ref_q <= kp_q;
              if (FAST) begin
                state_q <= S_HELD;
                cnt_q   <= '0;
              end else begin
                state_q <= S_PRESS;
                cnt_q   <= CNT_ONE;
              end
            end
          end
          S_PRESS: begin
            if (!ref_match) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end else if (accept) begin
              state_q <= S_HELD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          S_HELD: begin
            if (kp_zero) begin
              if (FAST) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
              end else begin
                state_q <= S_RELEASE;
                cnt_q   <= CNT_ONE;
              end
            end
          end
          S_RELEASE: begin
            // Any bounce back to a nonzero code means the key is still down.
            if (!kp_zero) begin
              state_q <= S_HELD;
              cnt_q   <= '0;
            end else if (cnt_inc == CNT_DONE) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign mins_tens    = digits_q[4*DIG_W-1 -: DIG_W];
  assign mins_ones    = digits_q[3*DIG_W-1 -: DIG_W];
  assign sec_tens     = digits_q[2*DIG_W-1 -: DIG_W];
  assign sec_ones     = digits_q[DIG_W-1   -: DIG_W];
  assign key_strobe   = strobe_q;
  assign time_nonzero = |digits_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed segment table, hand-written corner sequences and a
// randomized run, all checked against a digit-value reference model.
module tb_keypad_entry;

  localparam int D = 4;

  logic       clock;
  logic       clear;
  logic [9:0] keypad;
  logic       entry_en;
  logic       entry_clr;
  logic [3:0] mins_tens, mins_ones, sec_tens, sec_ones;
  logic       key_strobe;
  logic       time_nonzero;

  keypad_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock        (clock),
    .clear        (clear),
    .keypad       (keypad),
    .entry_en     (entry_en),
    .entry_clr    (entry_clr),
    .mins_tens    (mins_tens),
    .mins_ones    (mins_ones),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .key_strobe   (key_strobe),
    .time_nonzero (time_nonzero)
  );

  always #5 clock = ~clock;

  int checks;
  int errors;
  int seg_strobes;

  // Reference model: the entry is a 4-digit decimal number; a key is recognised after D
  // matching one-hot samples and re-armed after D consecutive empty samples.
  logic [9:0] m_kp;
  bit         m_latched;
  int         m_streak;
  logic [9:0] m_cand;
  int         m_val;
  bit         m_strobe;

  function automatic int key_index(input logic [9:0] k);
    for (int i = 0; i < 10; i++) if (k[i]) return i;
    return 0;
  endfunction

  function automatic int dut_val();
    return int'(mins_tens) * 1000 + int'(mins_ones) * 100 + int'(sec_tens) * 10 + int'(sec_ones);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [9:0] s;
    bit acc;
    s   = m_kp;
    acc = 0;
    m_kp = clear ? 10'h000 : keypad;
    if (clear) begin
      m_val = 0; m_latched = 0; m_streak = 0;
    end else if (!entry_en) begin
      m_latched = 0; m_streak = 0;
    end else begin
      if (!m_latched) begin
        if (m_streak == 0) begin
          if ($countones(s) == 1) begin m_cand = s; m_streak = 1; end
        end else if (s == m_cand) begin
          m_streak++;
        end else begin
          m_streak = 0;
        end
        if (m_streak == D) begin acc = 1; m_latched = 1; m_streak = 0; end
      end else begin
        if (s == 10'h000) m_streak++; else m_streak = 0;
        if (m_streak == D) begin m_latched = 0; m_streak = 0; end
      end
      if (entry_clr) m_val = acc ? key_index(m_cand) : 0;
      else if (acc) m_val = (m_val * 10 + key_index(m_cand)) % 10000;
    end
    m_strobe = acc;
  endtask

  task automatic step(input logic [9:0] kp, input logic en, input logic clr, input logic rst);
    keypad = kp; entry_en = en; entry_clr = clr; clear = rst;
    @(posedge clock);
    model_edge();
    #1;
    check("model_digits", dut_val(), m_val);
    check("model_strobe", int'(key_strobe), int'(m_strobe));
    check("model_nonzero", int'(time_nonzero), int'(m_val != 0));
    if (key_strobe) seg_strobes++;
  endtask

  typedef struct {
    logic [9:0] kp;
    bit         en;
    bit         clr;
    bit         rst;
    int         cycles;
    int         exp_val;
    int         exp_strobes;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [9:0] kp, input bit en, input bit clr, input bit rst,
                              input int cycles, input int exp_val, input int exp_strobes);
    vec_t v;
    v.kp = kp; v.en = en; v.clr = clr; v.rst = rst;
    v.cycles = cycles; v.exp_val = exp_val; v.exp_strobes = exp_strobes;
    return v;
  endfunction

  function automatic void press(input logic [9:0] kp, input int val_after);
    vecs.push_back(mk(kp, 1, 0, 0, 6, val_after, 1));
    vecs.push_back(mk(10'h000, 1, 0, 0, 5, val_after, 0));
  endfunction

  logic [9:0] r_kp;
  int         r_len;
  int         r_sel;
  bit         r_en;
  int         first_strobe;

  initial begin
    clock = 0; clear = 1; keypad = '0; entry_en = 1; entry_clr = 0;
    checks = 0; errors = 0; seg_strobes = 0;
    m_kp = '0; m_latched = 0; m_streak = 0; m_cand = '0; m_val = 0; m_strobe = 0;

    vecs.push_back(mk(10'h000, 1, 0, 1, 2, 0, 0));
    vecs.push_back(mk(10'h002, 1, 0, 0, 10, 1, 1));
    vecs.push_back(mk(10'h000, 1, 0, 0, 5, 1, 0));
    vecs.push_back(mk(10'h008, 1, 0, 0, 10, 13, 1));
    vecs.push_back(mk(10'h000, 1, 0, 0, 5, 13, 0));
    vecs.push_back(mk(10'h020, 1, 0, 0, 10, 135, 1));
    vecs.push_back(mk(10'h000, 1, 0, 0, 5, 135, 0));
    vecs.push_back(mk(10'h004, 1, 0, 0, 3, 135, 0));
    vecs.push_back(mk(10'h000, 1, 0, 0, 5, 135, 0));
    vecs.push_back(mk(10'h006, 1, 0, 0, 10, 135, 0));
    vecs.push_back(mk(10'h000, 1, 0, 0, 5, 135, 0));
    press(10'h002, 1351);
    press(10'h004, 3512);
    press(10'h008, 5123);
    press(10'h010, 1234);
    press(10'h020, 2345);
    vecs.push_back(mk(10'h200, 1, 0, 0, 40, 3459, 1));
    vecs.push_back(mk(10'h000, 1, 0, 0, 2, 3459, 0));
    vecs.push_back(mk(10'h200, 1, 0, 0, 1, 3459, 0));
    vecs.push_back(mk(10'h000, 1, 0, 0, 6, 3459, 0));
    vecs.push_back(mk(10'h000, 1, 1, 0, 1, 0, 0));
    press(10'h002, 1);
    press(10'h008, 13);
    press(10'h020, 135);
    vecs.push_back(mk(10'h080, 0, 0, 0, 10, 135, 0));
    vecs.push_back(mk(10'h080, 1, 0, 0, 8, 1357, 1));
    vecs.push_back(mk(10'h000, 1, 0, 0, 5, 1357, 0));
    vecs.push_back(mk(10'h000, 1, 1, 0, 1, 0, 0));
    press(10'h040, 6);
    vecs.push_back(mk(10'h004, 1, 0, 0, 2, 6, 0));
    vecs.push_back(mk(10'h004, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(10'h004, 1, 0, 0, 10, 2, 1));
    vecs.push_back(mk(10'h004, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(10'h004, 1, 0, 0, 10, 2, 1));
    vecs.push_back(mk(10'h000, 1, 0, 0, 5, 2, 0));

    foreach (vecs[i]) begin
      seg_strobes = 0;
      for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].kp, vecs[i].en, vecs[i].clr, vecs[i].rst);
      check($sformatf("vec%0d_digits", i), dut_val(), vecs[i].exp_val);
      check($sformatf("vec%0d_strobes", i), seg_strobes, vecs[i].exp_strobes);
      check($sformatf("vec%0d_nonzero", i), int'(time_nonzero), int'(vecs[i].exp_val != 0));
    end

    // Key 8 with entry_clr on its accept edge: strobe exactly 4 edges after kp_q loads, result 0008
    first_strobe = -1;
    for (int c = 0; c < 8; c++) begin
      step(10'h100, 1, (c == D), 0);
      if (key_strobe && first_strobe < 0) first_strobe = c;
      if (c == D) check("clr_on_accept_digits", dut_val(), 8);
    end
    check("accept_latency", first_strobe, D);
    for (int c = 0; c < 6; c++) step(10'h000, 1, 0, 0);
    check("after_clr_accept", dut_val(), 8);

    // Randomized segments against the model
    for (int n = 0; n < 400; n++) begin
      r_sel = $urandom_range(0, 99);
      r_en  = ($urandom_range(0, 99) >= 8);
      if (r_sel < 60) begin
        r_kp = 10'h001 << $urandom_range(0, 9); r_len = $urandom_range(1, 10);
      end else if (r_sel < 80) begin
        r_kp = 10'h000; r_len = $urandom_range(1, 8);
      end else begin
        r_kp = 10'($urandom); r_len = $urandom_range(1, 4);
      end
      for (int c = 0; c < r_len; c++)
        step(r_kp, r_en, r_en && ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
